// File: rtl/lab3_dg_keyscan.sv
// 4x4 matrix keypad scanner with row synchroniser and press/release debounce.
// Drives active-low one-hot columns and reports {row_n, col_n} of each accepted
// press on keypress, together with a single-cycle alarm strobe.
module lab3_dg_keyscan #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] keypress,
  output logic       alarm
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_sync [SYNC_STAGES];
  logic [3:0]    r_col, w_col_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [CW-1:0] r_db, w_db_nxt;
  logic [CW-1:0] r_rel, w_rel_nxt;
  logic [7:0]    r_cand, w_cand_nxt;
  logic [7:0]    r_keypress, w_keypress_nxt;
  logic          r_alarm, w_alarm_nxt;

  logic [3:0]    w_row_s;
  logic [3:0]    w_low;
  logic          w_one_low;
  logic          w_cap_high;
  logic [3:0]    w_col_adv;

  // Row synchroniser: the raw pins feed only the first stage.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= row_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_row_s    = r_sync[SYNC_STAGES-1];
  assign w_low      = ~w_row_s;
  assign w_one_low  = (w_low != 4'b0000) && ((w_low & (w_low - 4'b0001)) == 4'b0000);
  // Captured row is the single low bit of the candidate row nibble.
  assign w_cap_high = |(w_row_s & ~r_cand[7:4]);
  assign w_col_adv  = {r_col[2:0], r_col[3]};

  // State and datapath registers.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      r_state    <= SCAN;
      r_col      <= 4'b1110;
      r_dwell    <= '0;
      r_db       <= '0;
      r_rel      <= '0;
      r_cand     <= '1;
      r_keypress <= '1;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_dwell    <= w_dwell_nxt;
      r_db       <= w_db_nxt;
      r_rel      <= w_rel_nxt;
      r_cand     <= w_cand_nxt;
      r_keypress <= w_keypress_nxt;
      r_alarm    <= w_alarm_nxt;
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_dwell_nxt    = '0;
    w_db_nxt       = r_db;
    w_rel_nxt      = r_rel;
    w_cand_nxt     = r_cand;
    w_keypress_nxt = r_keypress;
    w_alarm_nxt    = 1'b0;
    unique case (r_state)
      SCAN: begin
        if (r_dwell == DW'(SCAN_DIV - 1)) begin
          if (w_one_low) begin
            w_cand_nxt  = {w_row_s, r_col};
            w_db_nxt    = CW'(1);
            w_state_nxt = DEBOUNCE;
          end else begin
            w_col_nxt = w_col_adv;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (w_row_s == r_cand[7:4]) begin
          if (r_db >= CW'(DEBOUNCE_CYCLES - 1)) begin
            w_db_nxt       = CW'(DEBOUNCE_CYCLES);
            w_keypress_nxt = r_cand;
            w_alarm_nxt    = 1'b1;
            w_state_nxt    = HELD;
          end else begin
            w_db_nxt = r_db + CW'(1);
          end
        end else begin
          w_db_nxt    = '0;
          w_col_nxt   = w_col_adv;
          w_state_nxt = SCAN;
        end
      end
      HELD: begin
        if (w_cap_high) begin
          w_rel_nxt   = CW'(1);
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (w_cap_high) begin
          if (r_rel >= CW'(DEBOUNCE_CYCLES - 1)) begin
            w_rel_nxt   = CW'(DEBOUNCE_CYCLES);
            w_col_nxt   = w_col_adv;
            w_state_nxt = SCAN;
          end else begin
            w_rel_nxt = r_rel + CW'(1);
          end
        end else begin
          w_state_nxt = HELD;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  assign col_n    = r_col;
  assign keypress = r_keypress;
  assign alarm    = r_alarm;

endmodule
